// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the intersection phase controller.
//   phase_e    : ALLRED -> GREEN -> YELLOW phase encoding
//   LED_G/Y/R  : bit positions inside each way's 3-bit {R,Y,G} LED field
//   LED_ALLRED : per-way LED value when the way shows red
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  localparam int unsigned LED_G = 0;
  localparam int unsigned LED_Y = 1;
  localparam int unsigned LED_R = 2;

  localparam logic [2:0] LED_ALLRED = 3'b100;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// tick_gen: timing-tick prescaler.
//   clk  : system clock
//   rst  : asynchronous reset, active-high (count returns to 0)
//   tick : high for exactly one clk out of every CLK_PER_TICK (while count is at its top value)
module tick_gen #(
  parameter int unsigned CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_PER_TICK);

  logic [CW-1:0] count;

  assign tick = (count == CW'(CLK_PER_TICK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-way traffic light phase controller.
// Way 0 is the main road and rests in GREEN; side ways 1..N_WAYS-1 are served
// only on latched sensor demand, in round-robin order.
//   clk          : system clock
//   rst          : asynchronous reset, active-high
//   sensor       : per-way vehicle sensor (level), bit 0 ignored
//   emerg        : emergency preemption request (only with TRAFFIC_PREEMPT_EN)
//   led          : per-way {R,Y,G} one-hot, way k at bits [3k+2:3k]
//   active_way   : way currently owning the phase
//   time_display : remaining ticks of the current phase
//   tick         : one-clk prescaler pulse
// Build option: define TRAFFIC_PREEMPT_EN to add the emerg input and
// emergency preemption toward way 0.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAYS       = 3,
  parameter int unsigned CLK_PER_TICK = 50_000_000,
  parameter int unsigned GREEN_T      = 30,
  parameter int unsigned YELLOW_T     = 3,
  parameter int unsigned ALLRED_T     = 1,
  parameter int unsigned TW           = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_WAYS-1:0]           sensor,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                        emerg,
`endif
  output logic [3*N_WAYS-1:0]         led,
  output logic [$clog2(N_WAYS)-1:0]   active_way,
  output logic [TW-1:0]               time_display,
  output logic                        tick
);

  localparam int unsigned AW = $clog2(N_WAYS);

  phase_e          phase;
  logic [TW-1:0]   cnt;
  logic [N_WAYS-1:0] req;
  logic [N_WAYS-1:0] req_set;
  logic [AW-1:0]   rr_ptr;
  logic [AW-1:0]   sel_way;
  logic            found;
  int unsigned     cand;
  logic            go_yellow;
  logic            emerg_i;
  logic            pend;

`ifdef TRAFFIC_PREEMPT_EN
  assign emerg_i = emerg;
`else
  assign emerg_i = 1'b0;
`endif

  assign time_display = cnt;

  tick_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  function automatic logic [3*N_WAYS-1:0] led_for(input phase_e p, input logic [AW-1:0] w);
    logic [3*N_WAYS-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      if (AW'(k) == w && p == PH_GREEN) begin
        v[3*k + LED_G] = 1'b1;
      end else if (AW'(k) == w && p == PH_YELLOW) begin
        v[3*k + LED_Y] = 1'b1;
      end else begin
        v[3*k + LED_R] = 1'b1;
      end
    end
    return v;
  endfunction

  // Demand latch: a way's sensor is masked while that way itself is green.
  always_comb begin
    req_set = req;
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      if (k != 0 && sensor[k] && !(phase == PH_GREEN && active_way == AW'(k))) begin
        req_set[k] = 1'b1;
      end
    end
  end

  // Next-way selection, consumed on the ALLRED exit edge. Uses registered
  // req only, so a request landing on that same edge waits for the next round.
  always_comb begin
    sel_way = '0;
    found   = 1'b0;
    cand    = 0;
    if (!(emerg_i || pend)) begin
      if (active_way != '0) begin
        for (int unsigned k = 1; k < N_WAYS; k++) begin
          if (!found && AW'(k) > active_way && req[k]) begin
            sel_way = AW'(k);
            found   = 1'b1;
          end
        end
      end else begin
        // Walk side ways starting just after rr_ptr, wrapping within 1..N_WAYS-1.
        for (int unsigned i = 1; i < N_WAYS; i++) begin
          cand = 32'(rr_ptr) + i;
          if (cand > N_WAYS - 1) begin
            cand = cand - (N_WAYS - 1);
          end
          if (!found && req[cand]) begin
            sel_way = AW'(cand);
            found   = 1'b1;
          end
        end
      end
    end
  end

  // Way 0 leaves GREEN only once its minimum green has run out and someone
  // is waiting; side ways leave at expiry or immediately on emergency.
  always_comb begin
    if (active_way == '0) begin
      go_yellow = (req != '0) && !emerg_i &&
                  ((cnt == '0) || (tick && cnt == TW'(1)));
    end else begin
      go_yellow = emerg_i || (tick && cnt == TW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= PH_ALLRED;
      active_way <= '0;
      cnt        <= TW'(ALLRED_T);
      led        <= {N_WAYS{LED_ALLRED}};
      req        <= '0;
      rr_ptr     <= '0;
      pend       <= 1'b0;
    end else begin
      req <= req_set;
      // Remember an emergency seen outside way-0 green so the next selection
      // is forced to way 0 even if emerg drops before ALLRED ends.
      if (emerg_i && !(phase == PH_GREEN && active_way == '0)) begin
        pend <= 1'b1;
      end
      case (phase)
        PH_ALLRED: begin
          if (tick && cnt == TW'(1)) begin
            phase        <= PH_GREEN;
            active_way   <= sel_way;
            cnt          <= TW'(GREEN_T);
            led          <= led_for(PH_GREEN, sel_way);
            req[sel_way] <= 1'b0;
            pend         <= 1'b0;
            if (sel_way != '0) begin
              rr_ptr <= sel_way;
            end
          end else if (tick) begin
            cnt <= cnt - TW'(1);
          end
        end
        PH_GREEN: begin
          if (go_yellow) begin
            phase <= PH_YELLOW;
            cnt   <= TW'(YELLOW_T);
            led   <= led_for(PH_YELLOW, active_way);
          end else if (tick && cnt != '0) begin
            cnt <= cnt - TW'(1);
          end
        end
        PH_YELLOW: begin
          if (tick && cnt == TW'(1)) begin
            phase <= PH_ALLRED;
            cnt   <= TW'(ALLRED_T);
            led   <= {N_WAYS{LED_ALLRED}};
          end else if (tick) begin
            cnt <= cnt - TW'(1);
          end
        end
        default: begin
          phase <= PH_ALLRED;
          cnt   <= TW'(ALLRED_T);
          led   <= {N_WAYS{LED_ALLRED}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed bench for traffic_phase_ctrl with
// N_WAYS=3, CLK_PER_TICK=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1.
// Preemption scenario runs only when TRAFFIC_PREEMPT_EN is defined.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] sensor;
  logic       emerg;
  logic [8:0] led;
  logic [1:0] active_way;
  logic [5:0] time_display;
  logic       tick;

  int unsigned total;
  int unsigned bad;

  // LED patterns, way 2 in the top field
  localparam logic [8:0] L_ALLRED = 9'b100_100_100;
  localparam logic [8:0] L_W0_G   = 9'b100_100_001;
  localparam logic [8:0] L_W0_Y   = 9'b100_100_010;
  localparam logic [8:0] L_W1_G   = 9'b100_001_100;
  localparam logic [8:0] L_W1_Y   = 9'b100_010_100;
  localparam logic [8:0] L_W2_G   = 9'b001_100_100;
  localparam logic [8:0] L_W2_Y   = 9'b010_100_100;

  traffic_phase_ctrl #(
    .N_WAYS       (3),
    .CLK_PER_TICK (4),
    .GREEN_T      (5),
    .YELLOW_T     (2),
    .ALLRED_T     (1),
    .TW           (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor       (sensor),
`ifdef TRAFFIC_PREEMPT_EN
    .emerg        (emerg),
`endif
    .led          (led),
    .active_way   (active_way),
    .time_display (time_display),
    .tick         (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [8:0] l,
                              input logic [1:0] w, input logic [5:0] td);
    check({tag, "_led"}, 32'(led), 32'(l));
    check({tag, "_way"}, 32'(active_way), 32'(w));
    check({tag, "_td"}, 32'(time_display), 32'(td));
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    sensor = '0;
    emerg  = 1'b0;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    expect_state("por", L_ALLRED, 2'd0, 6'd1);
    check("por_tick", 32'(tick), 32'd0);
    step(2);
    rst = 1'b0;
    step(4);
    expect_state("por_g0", L_W0_G, 2'd0, 6'd5);
    step(8);
    check("mid_green_td", 32'(time_display), 32'd3);

    // Reset pulse mid-GREEN takes effect without a clock edge
    rst = 1'b1;
    #1;
    expect_state("rst_mid", L_ALLRED, 2'd0, 6'd1);
    check("rst_mid_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    // Edge numbers below count from this release
    step(3);                                     // edge 3
    check("tick_first", 32'(tick), 32'd1);
    expect_state("allred_hold", L_ALLRED, 2'd0, 6'd1);
    step(1);                                     // edge 4
    check("tick_low", 32'(tick), 32'd0);
    expect_state("g0_entry", L_W0_G, 2'd0, 6'd5);

    // Idle hold on way 0
    step(19);                                    // edge 23
    expect_state("g0_last", L_W0_G, 2'd0, 6'd1);
    step(1);                                     // edge 24
    expect_state("g0_hold", L_W0_G, 2'd0, 6'd0);
    step(100);                                   // edge 124
    expect_state("g0_hold100", L_W0_G, 2'd0, 6'd0);

    // Single demand on way 2
    sensor = 3'b100;
    step(1);                                     // edge 125: req[2] latched
    sensor = 3'b000;
    check("dem_still_g", 32'(led), 32'(L_W0_G));
    step(1);                                     // edge 126
    expect_state("dem_y0", L_W0_Y, 2'd0, 6'd2);
    step(2);                                     // edge 128
    expect_state("dem_y0b", L_W0_Y, 2'd0, 6'd1);
    step(4);                                     // edge 132
    expect_state("dem_ar", L_ALLRED, 2'd0, 6'd1);
    step(4);                                     // edge 136
    expect_state("dem_g2", L_W2_G, 2'd2, 6'd5);
    step(19);                                    // edge 155
    expect_state("dem_g2_last", L_W2_G, 2'd2, 6'd1);
    step(1);                                     // edge 156
    expect_state("dem_y2", L_W2_Y, 2'd2, 6'd2);
    step(8);                                     // edge 164
    expect_state("dem_ar2", L_ALLRED, 2'd2, 6'd1);
    step(4);                                     // edge 168
    expect_state("dem_back0", L_W0_G, 2'd0, 6'd5);

    // Round-robin with both side sensors held
    sensor = 3'b110;
    step(20);                                    // edge 188
    expect_state("rr_y0", L_W0_Y, 2'd0, 6'd2);
    step(12);                                    // edge 200
    expect_state("rr_g1", L_W1_G, 2'd1, 6'd5);
    step(19);                                    // edge 219
    check("rr_g1_last", 32'(led), 32'(L_W1_G));
    step(1);                                     // edge 220: 20 clks of way 1 green
    check("rr_y1", 32'(led), 32'(L_W1_Y));
    step(12);                                    // edge 232
    expect_state("rr_g2", L_W2_G, 2'd2, 6'd5);
    step(19);                                    // edge 251
    check("rr_g2_last", 32'(led), 32'(L_W2_G));
    step(1);                                     // edge 252
    check("rr_y2", 32'(led), 32'(L_W2_Y));
    step(12);                                    // edge 264
    expect_state("rr_g0", L_W0_G, 2'd0, 6'd5);
    sensor = 3'b000;
    step(32);                                    // edge 296
    expect_state("rr_g1b", L_W1_G, 2'd1, 6'd5);
    step(32);                                    // edge 328: req[2] still pending
    expect_state("rr_g2b", L_W2_G, 2'd2, 6'd5);
    step(32);                                    // edge 360
    expect_state("rr_g0b", L_W0_G, 2'd0, 6'd5);
    step(20);                                    // edge 380
    expect_state("rr_hold", L_W0_G, 2'd0, 6'd0);

    // Sensor pulsed during way 1's own green gives no repeat service
    sensor = 3'b010;
    step(1);                                     // edge 381
    sensor = 3'b000;
    step(1);                                     // edge 382
    expect_state("own_y0", L_W0_Y, 2'd0, 6'd2);
    step(10);                                    // edge 392
    expect_state("own_g1", L_W1_G, 2'd1, 6'd5);
    sensor = 3'b010;
    step(3);                                     // edge 395
    sensor = 3'b000;
    step(29);                                    // edge 424
    expect_state("own_g0", L_W0_G, 2'd0, 6'd5);
    step(40);                                    // edge 464
    expect_state("own_hold", L_W0_G, 2'd0, 6'd0);

`ifdef TRAFFIC_PREEMPT_EN
    // Emergency preemption during way 2 green, with way 1 pending
    sensor = 3'b100;
    step(1);                                     // edge 465
    sensor = 3'b000;
    step(11);                                    // edge 476
    expect_state("pe_g2", L_W2_G, 2'd2, 6'd5);
    step(4);                                     // edge 480
    check("pe_g2_td4", 32'(time_display), 32'd4);
    emerg  = 1'b1;
    sensor = 3'b010;
    step(1);                                     // edge 481
    sensor = 3'b000;
    expect_state("pe_y2", L_W2_Y, 2'd2, 6'd2);
    step(11);                                    // edge 492
    expect_state("pe_g0", L_W0_G, 2'd0, 6'd5);
    step(68);                                    // edge 560: held despite req[1]
    expect_state("pe_hold", L_W0_G, 2'd0, 6'd0);
    emerg = 1'b0;
    step(1);                                     // edge 561
    expect_state("pe_rel_y0", L_W0_Y, 2'd0, 6'd2);
    step(11);                                    // edge 572
    expect_state("pe_g1", L_W1_G, 2'd1, 6'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
